// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the instruction-fetch and data ports.
// Data normally wins; a starvation counter lets a waiting fetch through, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        sram_req,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ack,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_MAX   = 8'(MAX_WAIT);

    state_t      state, state_next;
    logic        mem_pend;
    logic        grant_if, grant_d, timeout;
    logic        win_d;
    logic        we_q;
    logic [7:0]  starve_cnt;
    logic [7:0]  wait_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= STARVE_MAX) ? STARVE_MAX : v + 8'd1;
    endfunction

    assign mem_pend = mem_r_en | mem_w_en;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                // A fetch that has watched STARVE_LIMIT data grants in a row gets the next slot.
                if (mem_pend && !(if_req && starve_cnt == STARVE_MAX)) grant_d = 1'b1;
                else if (if_req)                                        grant_if = 1'b1;
                if (grant_d || grant_if) state_next = BUSY;
            end
            BUSY: begin
                if (sram_ack) begin
                    state_next = RESP;
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_d      <= 1'b0;
            we_q       <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            err        <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (grant_if || !if_req) starve_cnt <= '0;
                else if (grant_d)        starve_cnt <= sat_inc(starve_cnt);
            end
            if (grant_d || grant_if) begin
                win_d      <= grant_d;
                we_q       <= grant_d & mem_w_en;
                sram_addr  <= grant_d ? mem_addr : if_addr;
                sram_wdata <= grant_d ? mem_wdata : 32'h0;
                // The first BUSY cycle counts as wait cycle one.
                wait_cnt   <= 8'd1;
            end else if (state == BUSY && !sram_ack && !timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == BUSY && sram_ack) begin
                if (!we_q) begin
                    if (win_d) mem_rdata <= sram_rdata;
                    else       if_rdata  <= sram_rdata;
                end
            end else if (timeout) begin
                err <= 1'b1;
                if (win_d) mem_rdata <= '0;
                else       if_rdata  <= '0;
            end
        end
    end

    assign sram_req  = (state == BUSY);
    assign sram_we   = (state == BUSY) & we_q;
    assign if_ready  = (state == RESP) & ~win_d;
    assign mem_ready = (state == RESP) &  win_d;
    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_pend & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus
// hand-written starvation, watchdog, reset and stray-ack sequences.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req;
    logic [31:0] if_addr, if_rdata;
    logic        if_ready, if_stall;
    logic        mem_r_en, mem_w_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, mem_stall;
    logic        sram_req, sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_ack, err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_stall(mem_stall),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ack(sram_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        t_if, t_r, t_w;
        logic [31:0] addr, wdata;
        int          ack_at;
        logic [31:0] ack_data;
        int          exp_lat;
        logic [31:0] exp_rd, exp_other;
    } vec_t;

    // Called at #1 into an IDLE cycle (cycle 0). ack_at = busy cycle that acks, 0 = never.
    // Returns at #1 into the IDLE cycle following the ready pulse.
    task automatic do_txn(input logic t_if, t_r, t_w, input logic [31:0] addr, wdata,
                          input int ack_at, input logic [31:0] ack_data,
                          output int lat, output int busy_n, output logic seen_we,
                          output logic [31:0] seen_addr, seen_wdata,
                          output logic other_pulse, output logic stall_bad);
        lat = -1; busy_n = 0; seen_we = 1'b0; seen_addr = '0; seen_wdata = '0;
        other_pulse = 1'b0; stall_bad = 1'b0;
        if_req = t_if; if_addr = addr;
        mem_r_en = t_r; mem_w_en = t_w; mem_addr = addr; mem_wdata = wdata;
        #1;
        if ((t_if ? if_stall : mem_stall) !== 1'b1) stall_bad = 1'b1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            step();
            sram_ack = 1'b0;
            if (sram_req) begin
                busy_n++;
                if (busy_n == 1) begin
                    seen_we = sram_we; seen_addr = sram_addr; seen_wdata = sram_wdata;
                end
                if (busy_n == ack_at) begin
                    sram_ack = 1'b1; sram_rdata = ack_data;
                end
            end
            if (t_if ? mem_ready : if_ready) other_pulse = 1'b1;
            if (t_if ? if_ready : mem_ready) begin
                lat = c;
                if ((t_if ? if_stall : mem_stall) !== 1'b0) stall_bad = 1'b1;
            end else if ((t_if ? if_stall : mem_stall) !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ack = 1'b0;
        step();
        if (if_ready || mem_ready) other_pulse = 1'b1;
    endtask

    vec_t vecs[5];
    int          lat, busy_n;
    logic        seen_we, other_pulse, stall_bad;
    logic [31:0] seen_addr, seen_wdata;
    logic        got_if[10];
    logic        exp_if[10];
    int          k;
    logic        bad;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hE3A0_1005, 4, 32'hE3A0_1005, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1, 32'hDEAD_DEAD, 2, 32'h0, 32'hE3A0_1005};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 2, 32'hCAFE_BABE, 3, 32'hCAFE_BABE, 32'hE3A0_1005};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0804, 32'h0BAD_F00D, 1, 32'h7777_7777, 2, 32'hCAFE_BABE, 32'hE3A0_1005};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1, 32'h1111_2222, 2, 32'h1111_2222, 32'hCAFE_BABE};

        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        mem_addr = '0; mem_wdata = '0; sram_rdata = '0; sram_ack = 1'b0;
        repeat (3) step();
        chk("rst_sram_req", {31'b0, sram_req}, 32'h0);
        chk("rst_sram_we", {31'b0, sram_we}, 32'h0);
        chk("rst_ready", {30'b0, if_ready, mem_ready}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_sram_addr", sram_addr, 32'h0);
        chk("rst_sram_wdata", sram_wdata, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i].t_if, vecs[i].t_r, vecs[i].t_w, vecs[i].addr, vecs[i].wdata,
                   vecs[i].ack_at, vecs[i].ack_data,
                   lat, busy_n, seen_we, seen_addr, seen_wdata, other_pulse, stall_bad);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), vecs[i].t_if ? if_rdata : mem_rdata, vecs[i].exp_rd);
            chk($sformatf("v%0d_other_rdata", i), vecs[i].t_if ? mem_rdata : if_rdata, vecs[i].exp_other);
            chk($sformatf("v%0d_sram_we", i), {31'b0, seen_we}, {31'b0, vecs[i].t_w});
            chk($sformatf("v%0d_sram_addr", i), seen_addr, vecs[i].addr);
            if (vecs[i].t_w) chk($sformatf("v%0d_sram_wdata", i), seen_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_pulse_shape", i), {31'b0, other_pulse}, 32'h0);
            chk($sformatf("v%0d_stall", i), {31'b0, stall_bad}, 32'h0);
            chk($sformatf("v%0d_err", i), {31'b0, err}, 32'h0);
        end

        // Starvation: both ports held, backend acks every BUSY cycle.
        exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        if_req = 1'b1; if_addr = 32'h100; mem_r_en = 1'b1; mem_addr = 32'h200;
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            step();
            sram_ack = sram_req;
            sram_rdata = 32'hA5A5_0000 + 32'(k);
            if (if_ready)  begin got_if[k] = 1'b1; k++; end
            else if (mem_ready) begin got_if[k] = 1'b0; k++; end
        end
        if_req = 1'b0; mem_r_en = 1'b0; sram_ack = 1'b0;
        chk("starve_grant_count", 32'(k), 32'd10);
        for (int i = 0; i < k; i++)
            chk($sformatf("starve_grant%0d_is_if", i), {31'b0, got_if[i]}, {31'b0, exp_if[i]});
        step();

        // Watchdog abort.
        do_txn(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0,
               lat, busy_n, seen_we, seen_addr, seen_wdata, other_pulse, stall_bad);
        chk("abort_busy_cycles", 32'(busy_n), 32'd15);
        chk("abort_latency", 32'(lat), 32'd16);
        chk("abort_mem_rdata", mem_rdata, 32'h0);
        chk("abort_err", {31'b0, err}, 32'h1);
        repeat (3) step();
        chk("abort_err_sticky", {31'b0, err}, 32'h1);

        // Reset in the middle of BUSY.
        mem_r_en = 1'b1; mem_addr = 32'h500;
        step();
        chk("rstmid_busy", {31'b0, sram_req}, 32'h1);
        step();
        rst = 1'b1; mem_r_en = 1'b0;
        step();
        chk("rstmid_sram_req", {31'b0, sram_req}, 32'h0);
        chk("rstmid_err", {31'b0, err}, 32'h0);
        chk("rstmid_if_rdata", if_rdata, 32'h0);
        rst = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            step();
            if (sram_req || if_ready || mem_ready) bad = 1'b1;
        end
        chk("rstmid_no_ready", {31'b0, bad}, 32'h0);

        // Ack on the same cycle the watchdog would fire.
        do_txn(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 15, 32'h5EED_0001,
               lat, busy_n, seen_we, seen_addr, seen_wdata, other_pulse, stall_bad);
        chk("acktmo_latency", 32'(lat), 32'd16);
        chk("acktmo_rdata", mem_rdata, 32'h5EED_0001);
        chk("acktmo_err", {31'b0, err}, 32'h0);

        // Stray ack while idle.
        sram_ack = 1'b1; sram_rdata = 32'hFFFF_FFFF;
        step();
        sram_ack = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            if (sram_req || if_ready || mem_ready) bad = 1'b1;
            step();
        end
        chk("stray_no_activity", {31'b0, bad}, 32'h0);
        chk("stray_mem_rdata", mem_rdata, 32'h5EED_0001);
        chk("stray_if_rdata", if_rdata, 32'h0);
        do_txn(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 1, 32'h1357_2468,
               lat, busy_n, seen_we, seen_addr, seen_wdata, other_pulse, stall_bad);
        chk("stray_next_latency", 32'(lat), 32'd2);
        chk("stray_next_rdata", mem_rdata, 32'h1357_2468);
        chk("stray_err", {31'b0, err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
